memory_stage: RTL and testbench

- MEM stage of the 5-stage pipeline, directly downstream of the execute stage.
- Consumes the EX/MEM register outputs (control, ALU result, store data, destination register).
- Performs word-wide data-memory store/load and holds the MEM/WB pipeline register.
- Drives ResultW, the writeback value returned to the register file and to the execute-stage forwarding mux.

---
 rtl/memory_stage_pkg.sv | 13 +
 rtl/memory_stage_data_memory.sv | 25 ++
 rtl/memory_stage.sv | 77 +++++++
 tb/tb_memory_stage.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/memory_stage_pkg.sv
// Shared widths and the MEM/WB control bundle for the memory stage.
package memory_stage_pkg;

  localparam int WORD_W        = 32;
  localparam int REG_ADDR_W    = 5;
  localparam int DEPTH_DEFAULT = 64;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } memwb_ctrl_t;

endpackage

// File: rtl/memory_stage_data_memory.sv
// Word-wide data memory: combinational read, write on the rising clock edge.
// Contents have no reset; an unwritten word reads as X.
module data_memory #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wd,
  output logic [31:0]       rd
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wd;
    end
  end

  // Read sees the pre-edge word, so a same-cycle store is visible one cycle later.
  assign rd = mem[addr];

endmodule

// File: rtl/memory_stage.sv
// MEM stage: data-memory access, MEM/WB pipeline register and writeback mux.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int ADDR_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteM,
  input  logic                  MemtoRegM,
  input  logic                  MemWriteM,
  input  logic [WORD_W-1:0]     ALUOutM,
  input  logic [WORD_W-1:0]     WriteDataM,
  input  logic [REG_ADDR_W-1:0] WriteRegM,
  output logic                  RegWriteW,
  output logic                  MemtoRegW,
  output logic [REG_ADDR_W-1:0] WriteRegW,
  output logic [WORD_W-1:0]     ReadDataW,
  output logic [WORD_W-1:0]     ALUOutW,
  output logic [WORD_W-1:0]     ResultW
);

  logic [WORD_W-1:0]     read_data_m;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_idx;

  memwb_ctrl_t           ctrl_d,      ctrl_q;
  logic [REG_ADDR_W-1:0] write_reg_d, write_reg_q;
  logic [WORD_W-1:0]     read_data_d, read_data_q;
  logic [WORD_W-1:0]     alu_out_d,   alu_out_q;

  // Byte address to word index; low two bits and upper bits are dropped.
  assign mem_idx = ALUOutM[ADDR_W+1:2];
  assign mem_we  = MemWriteM & ~rst;

  data_memory #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_dmem (
    .clk  (clk),
    .we   (mem_we),
    .addr (mem_idx),
    .wd   (WriteDataM),
    .rd   (read_data_m)
  );

  always_comb begin
    ctrl_d.reg_write  = RegWriteM;
    ctrl_d.mem_to_reg = MemtoRegM;
    write_reg_d       = WriteRegM;
    read_data_d       = read_data_m;
    alu_out_d         = ALUOutM;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q      <= '0;
      write_reg_q <= '0;
      read_data_q <= '0;
      alu_out_q   <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      write_reg_q <= write_reg_d;
      read_data_q <= read_data_d;
      alu_out_q   <= alu_out_d;
    end
  end

  assign RegWriteW = ctrl_q.reg_write;
  assign MemtoRegW = ctrl_q.mem_to_reg;
  assign WriteRegW = write_reg_q;
  assign ReadDataW = read_data_q;
  assign ALUOutW   = alu_out_q;
  assign ResultW   = ctrl_q.mem_to_reg ? read_data_q : alu_out_q;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios plus random traffic
// checked against a word-array reference model.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, MemtoRegM, MemWriteM;
  logic [31:0] ALUOutM, WriteDataM;
  logic [4:0]  WriteRegM;
  logic        RegWriteW, MemtoRegW;
  logic [4:0]  WriteRegW;
  logic [31:0] ReadDataW, ALUOutW, ResultW;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] ref_mem   [64];
  bit          ref_known [64];
  logic        e_rw, e_m2r;
  logic [4:0]  e_wr;
  logic [31:0] e_rd, e_alu;
  bit          e_rd_known;

  memory_stage #(.DEPTH(64), .ADDR_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .RegWriteM  (RegWriteM),
    .MemtoRegM  (MemtoRegM),
    .MemWriteM  (MemWriteM),
    .ALUOutM    (ALUOutM),
    .WriteDataM (WriteDataM),
    .WriteRegM  (WriteRegM),
    .RegWriteW  (RegWriteW),
    .MemtoRegW  (MemtoRegW),
    .WriteRegW  (WriteRegW),
    .ReadDataW  (ReadDataW),
    .ALUOutW    (ALUOutW),
    .ResultW    (ResultW)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_w();
    check_eq("RegWriteW", {31'd0, RegWriteW}, {31'd0, e_rw});
    check_eq("MemtoRegW", {31'd0, MemtoRegW}, {31'd0, e_m2r});
    check_eq("WriteRegW", {27'd0, WriteRegW}, {27'd0, e_wr});
    check_eq("ALUOutW", ALUOutW, e_alu);
    if (e_rd_known) begin
      check_eq("ReadDataW", ReadDataW, e_rd);
      check_eq("ResultW", ResultW, e_m2r ? e_rd : e_alu);
    end else if (!e_m2r) begin
      check_eq("ResultW", ResultW, e_alu);
    end
  endtask

  // One pipeline cycle: drive M inputs, clock, update model, check W outputs.
  task automatic cyc(input logic r, input logic rw, input logic m2r, input logic mw,
                     input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr);
    int idx;
    rst = r; RegWriteM = rw; MemtoRegM = m2r; MemWriteM = mw;
    ALUOutM = alu; WriteDataM = wd; WriteRegM = wr;
    @(posedge clk);
    idx = (alu / 4) % 64;
    if (r) begin
      e_rw = 0; e_m2r = 0; e_wr = 0; e_rd = 0; e_alu = 0; e_rd_known = 1;
    end else begin
      e_rw = rw; e_m2r = m2r; e_wr = wr; e_alu = alu;
      e_rd = ref_mem[idx]; e_rd_known = ref_known[idx];
      if (mw) begin
        ref_mem[idx]   = wd;
        ref_known[idx] = 1;
      end
    end
    #1;
    check_w();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_known[i] = 0;
    e_rd_known = 0;

    // Reset with a store presented: store must be dropped, W all zero.
    cyc(1, 1, 0, 1, 32'h10, 32'hDEADBEEF, 5'd3);
    cyc(1, 1, 0, 1, 32'h10, 32'hDEADBEEF, 5'd3);
    check_eq("rst_result_zero", ResultW, 32'h0);
    cyc(0, 1, 1, 0, 32'h10, 32'h0, 5'd4);
    check_eq("rst_store_dropped", {31'd0, ReadDataW === 32'hDEADBEEF}, 32'd0);

    // Fill every word so later loads have known contents.
    for (int i = 0; i < 64; i++) cyc(0, 0, 0, 1, i * 4, $urandom, 5'd0);

    // Store then load.
    cyc(0, 0, 0, 1, 32'h20, 32'h12345678, 5'd0);
    cyc(0, 1, 1, 0, 32'h20, 32'h0, 5'd5);
    check_eq("st_ld_result", ResultW, 32'h12345678);
    check_eq("st_ld_wreg", {27'd0, WriteRegW}, 32'd5);

    // Read during write returns the old word.
    cyc(0, 0, 0, 1, 32'h08, 32'h1, 5'd0);
    cyc(0, 1, 1, 1, 32'h08, 32'h2, 5'd6);
    check_eq("rdw_old", ReadDataW, 32'h1);
    cyc(0, 1, 1, 0, 32'h08, 32'h0, 5'd6);
    check_eq("rdw_new", ResultW, 32'h2);

    // Address wrap and ignored low bits.
    cyc(0, 0, 0, 1, 32'h103, 32'hCAFEF00D, 5'd0);
    cyc(0, 1, 1, 0, 32'h000, 32'h0, 5'd7);
    check_eq("wrap_load", ResultW, 32'hCAFEF00D);

    // ALU pass-through, then confirm memory untouched.
    cyc(0, 1, 0, 0, 32'h0000ABCD, 32'hFFFFFFFF, 5'd9);
    check_eq("alu_result", ResultW, 32'h0000ABCD);
    check_eq("alu_wreg", {27'd0, WriteRegW}, 32'd9);
    cyc(0, 1, 1, 0, 32'h0000ABCD, 32'h0, 5'd9);

    // Bubble, load in flight, mid-stream reset, then resume.
    cyc(0, 0, 0, 0, 32'h20, 32'h0, 5'd1);
    check_eq("bubble_rw", {31'd0, RegWriteW}, 32'd0);
    cyc(0, 1, 1, 0, 32'h20, 32'h0, 5'd10);
    cyc(1, 1, 1, 1, 32'h20, 32'h55555555, 5'd10);
    check_eq("midrst_rw", {31'd0, RegWriteW}, 32'd0);
    check_eq("midrst_result", ResultW, 32'h0);
    cyc(0, 1, 1, 0, 32'h20, 32'h0, 5'd11);
    check_eq("resume_load", ResultW, 32'h12345678);

    // Random traffic; small index range to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = {$urandom_range(0, 255), 2'b00, 4'h0, 4'($urandom_range(0, 15)), 2'($urandom)};
      cyc($urandom_range(0, 19) == 0, 1'($urandom), 1'($urandom), 1'($urandom),
          a, $urandom, 5'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
